// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer that drives the CPU's memory, PC, IR and accumulator strobes.
// Optional SINGLE_STEP_EN adds a step input; the sequencer then waits in phase 0 after each instruction.
module seq_controller #(
  parameter int OPC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPC_WIDTH-1:0] opcode,
  input  logic                 zero,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 halt,
  output logic                 inc_pc,
  output logic                 ld_pc,
  output logic                 ld_ac,
  output logic                 wr,
  output logic                 data_e,
  output logic [2:0]           phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPC_WIDTH-1:0] OPC_HLT = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OPC_SKZ = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_ADD = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OPC_AND = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OPC_XOR = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OPC_LDA = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OPC_STO = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OPC_JMP = OPC_WIDTH'(7);

  phase_t state;
  logic   halted;
  logic   alu_op;

`ifdef SINGLE_STEP_EN
  // Set when an instruction completes; cleared only by reset or an accepted step.
  logic hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
      hold   <= 1'b0;
    end else if (!halted) begin
      if (state == OP_ADDR && opcode == OPC_HLT) begin
        halted <= 1'b1;
        state  <= OP_FETCH;
      end else if (state == INST_ADDR && hold) begin
        if (step) begin
          hold  <= 1'b0;
          state <= INST_FETCH;
        end
      end else begin
        if (state == STORE) hold <= 1'b1;
        state <= phase_t'(state + 3'd1);
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (state == OP_ADDR && opcode == OPC_HLT) begin
        halted <= 1'b1;
        state  <= OP_FETCH;
      end else begin
        state <= phase_t'(state + 3'd1);
      end
    end
  end
`endif

  assign alu_op = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                  (opcode == OPC_XOR) || (opcode == OPC_LDA);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (!halted) begin
      unique case (state)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    inc_pc = 1'b1;
        OP_FETCH:   rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OPC_SKZ) && zero;
          ld_pc  = (opcode == OPC_JMP);
          data_e = (opcode == OPC_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OPC_JMP);
          wr     = (opcode == OPC_STO);
          data_e = (opcode == OPC_STO);
        end
        default: ;
      endcase
    end
  end

  assign halt  = halted;
  assign phase = state;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: a spec-level model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       step;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];

  // Reference model state: phase number, halted flag, waiting-for-step flag.
  int m_phase;
  bit m_halted;
  bit m_hold;

  always #5 clk = ~clk;

  seq_controller #(.OPC_WIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
`ifdef SINGLE_STEP_EN
    .step   (step),
`endif
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .phase  (phase)
  );

  // Packed view: {phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e}
  function automatic logic [11:0] dut_vec();
    return {phase, sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};
  endfunction

  function automatic logic [11:0] model_out(int ph, bit hlt, logic [2:0] opc, logic z);
    bit alu, s, r, ir, ipc, lpc, lac, w, de;
    alu = (opc >= 3'd2) && (opc <= 3'd5);
    if (hlt) return {3'(ph), 9'b000100000};
    s   = (ph <= 3);
    r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ir  = (ph == 2 || ph == 3);
    ipc = (ph == 4) || (ph == 6 && opc == 3'd1 && z);
    lpc = (ph == 6 || ph == 7) && opc == 3'd7;
    lac = (ph == 7) && alu;
    w   = (ph == 7) && opc == 3'd6;
    de  = (ph == 6 || ph == 7) && opc == 3'd6;
    return {3'(ph), s, r, ir, 1'b0, ipc, lpc, lac, w, de};
  endfunction

  // Advance the model by one rising edge using the inputs that were present at that edge.
  task automatic model_step();
    if (m_halted) return;
    if (m_phase == 4 && opcode == 3'd0) begin
      m_halted = 1'b1;
      m_phase  = 5;
    end
`ifdef SINGLE_STEP_EN
    else if (m_phase == 0 && m_hold) begin
      if (step) begin
        m_hold  = 1'b0;
        m_phase = 1;
      end
    end
`endif
    else begin
      if (m_phase == 7) m_hold = 1'b1;
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic check_vec(string name, logic [11:0] got, logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got phase=%0d strobes=%b, required phase=%0d strobes=%b (t=%0t)",
               name, got[11:9], got[8:0], exp[11:9], exp[8:0], $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_vec("cycle_outputs", dut_vec(), exp_q.pop_front());
    if (rst !== 1'b1) begin
      checks++;
      if ((inc_pc & ld_pc) !== 1'b0) begin
        failures++;
        $display("FAIL inc_ld_exclusive: inc_pc=%b ld_pc=%b, required not both 1", inc_pc, ld_pc);
      end
      checks++;
      if ((wr & ~data_e) !== 1'b0) begin
        failures++;
        $display("FAIL wr_needs_data_e: wr=%b data_e=%b, required wr only with data_e", wr, data_e);
      end
    end
  end

  task automatic cycle(input logic [2:0] opc, input logic z, input logic st);
    @(posedge clk);
    #1;
    model_step();
    opcode = opc;
    zero   = z;
    step   = st;
    exp_q.push_back(model_out(m_phase, m_halted, opcode, zero));
  endtask

  // Asserts reset between edges, checks the asynchronous effect, releases after the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_vec("async_reset", dut_vec(), {3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    m_hold   = 1'b0;
    exp_q.push_back(model_out(m_phase, m_halted, opcode, zero));
  endtask

  task automatic directed(input logic [2:0] opc, input logic z);
    opcode = opc;
    zero   = z;
    step   = 1'b1;
    do_reset();
    repeat (8) cycle(opc, z, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    step   = 1'b1;
    m_phase = 0; m_halted = 1'b0; m_hold = 1'b0;

    do_reset();
    repeat (5) cycle(3'd2, 1'b0, 1'b1);
    do_reset();

    directed(3'd2, 1'b0);
    directed(3'd1, 1'b1);
    directed(3'd1, 1'b0);
    directed(3'd7, 1'b0);
    directed(3'd6, 1'b1);
    directed(3'd3, 1'b1);

    directed(3'd0, 1'b0);
    repeat (20) cycle(3'd0, 1'b0, 1'b1);
    checks++;
    if (!(m_halted && m_phase == 5)) begin
      failures++;
      $display("FAIL hlt_model_state: halted=%0d phase=%0d, required halted=1 phase=5", m_halted, m_phase);
    end
    do_reset();
    repeat (8) cycle(3'd5, 1'b0, 1'b1);

`ifdef SINGLE_STEP_EN
    opcode = 3'd2; zero = 1'b0; step = 1'b1;
    do_reset();
    repeat (7) cycle(3'd2, 1'b0, 1'b1);
    cycle(3'd2, 1'b0, 1'b0);
    repeat (10) cycle(3'd2, 1'b0, 1'b0);
    cycle(3'd2, 1'b0, 1'b1);
    repeat (3) cycle(3'd2, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [2:0] opc;
      logic       st;
      opc = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
`ifdef SINGLE_STEP_EN
      st = ($urandom_range(0, 2) != 0);
`else
      st = 1'b1;
`endif
      cycle(opc, 1'($urandom_range(0, 1)), st);
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end

    @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter OPC_WIDTH, default 3, opcode field width; only 3 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  OPC_WIDTH  instruction-register opcode; 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
REQ-005 zero  input  1  accumulator-is-zero flag.
REQ-006 sel  output  1  memory address mux: 1 = program counter, 0 = instruction operand.
REQ-007 rd  output  1  memory read enable.
REQ-008 ld_ir  output  1  instruction register load.
REQ-009 halt  output  1  processor halted, sticky.
REQ-010 inc_pc  output  1  drives the program counter's enab.
REQ-011 ld_pc  output  1  drives the program counter's load.
REQ-012 ld_ac  output  1  accumulator load.
REQ-013 wr  output  1  memory write strobe.
REQ-014 data_e  output  1  accumulator-to-data-bus tristate enable.
REQ-015 phase  output  3  current phase, for debug and bench.

Function
REQ-016 The block SHALL be an 8-phase sequencer: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-017 Phase SHALL advance by one per clock, wrapping 7 -> 0, unless halted or paused (REQ-024, REQ-029).
REQ-018 Outputs SHALL be a combinational function of phase, opcode and zero; ALUOP = ADD, AND, XOR or LDA.
REQ-019 Phases 0-3: sel=1; rd=1 in phases 1-3; ld_ir=1 in phases 2-3; all other strobes 0.
REQ-020 Phase 4: sel=0, inc_pc=1, all other strobes 0.
REQ-021 Phase 5: rd=ALUOP.
REQ-022 Phase 6: rd=ALUOP, inc_pc=(SKZ and zero), ld_pc=JMP, data_e=STO.
REQ-023 Phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
REQ-024 If opcode=HLT in phase 4, the halted flag SHALL be set on that edge: phase freezes at 5 and halt=1 from the next cycle. All strobes are 0 while halted, inc_pc included.
REQ-025 inc_pc and ld_pc SHALL never both be 1 in the same cycle.
REQ-026 wr SHALL be 1 only when data_e is 1.
REQ-027 Opcode changes outside phases 4-7 SHALL have no effect on the strobes.

Reset
REQ-028 rst=1 SHALL immediately force phase=0 and halted=0, independent of clk. All outputs are then 0 except sel=1; the first phase advance occurs on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro SINGLE_STEP_EN, when defined, adds input step (1 bit). After completing phase 7 the sequencer SHALL hold in phase 0 until step=1 is sampled on a rising edge, then proceed to phase 1. Reset does not require a step to leave phase 0.
REQ-030 Without SINGLE_STEP_EN, the step port SHALL be absent and the sequencer free-runs per REQ-017.

Verification
REQ-031 rst pulse mid-phase 5 -> phase=0, sel=1, other strobes 0 asynchronously, before the next edge.
REQ-032 opcode=2 (ADD), 8 clocks from reset -> phases 0..7 in order; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4; wr=0 throughout.
REQ-033 opcode=1 (SKZ): zero=1 gives inc_pc=1 in phases 4 and 6; zero=0 gives inc_pc=1 in phase 4 only.
REQ-034 opcode=7 (JMP) -> ld_pc=1 in phases 6-7 with inc_pc=0 there; opcode=6 (STO) -> data_e=1 in phases 6-7, wr=1 in phase 7 only.
REQ-035 opcode=0 (HLT) -> halt=1 from the cycle after phase 4; phase stays 5 for 20 clocks with all strobes 0; rst then restarts from phase 0.
REQ-036 With SINGLE_STEP_EN, step=0 -> phase holds 0 for 10 clocks after the first instruction; one step pulse -> phase 1 on the next edge.
